// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box types, tower-field constants and GF(2)/GF(2^2)/GF(2^4) helpers.
// Field tower: GF(2^2)=x^2+x+1, GF(2^4)=y^2+y+PHI, GF(2^8)=z^2+z+LAMBDA.
package aes_sbox_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } isb_state_e;

  localparam logic [7:0] AFFINE_C     = 8'h63;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;

  localparam logic [1:0] GF4_PHI    = 2'b10;
  localparam logic [3:0] GF8_LAMBDA = 4'b1100;

  // Row r is the mask of input bits XORed into output bit r.
  localparam logic [7:0][7:0] ISO_MAP = {
    8'hA0, 8'hDE, 8'hAC, 8'hAE, 8'hC6, 8'h9E, 8'h52, 8'h43
  };
  localparam logic [7:0][7:0] INV_ISO_MAP = {
    8'hE2, 8'h44, 8'h62, 8'h76, 8'h3E, 8'h9E, 8'h30, 8'h75
  };

  function automatic logic [7:0] bit_mat_mul(input logic [7:0][7:0] m, input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = ^(m[i] & b);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]);
    r[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
    return r;
  endfunction

  function automatic logic [1:0] gf2_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh, hl, lh, ll;
    hh = gf2_mul(a[3:2], b[3:2]);
    hl = gf2_mul(a[3:2], b[1:0]);
    lh = gf2_mul(a[1:0], b[3:2]);
    ll = gf2_mul(a[1:0], b[1:0]);
    return {hh ^ hl ^ lh, gf2_mul(hh, GF4_PHI) ^ ll};
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    logic [1:0] hs;
    hs = gf2_sq(a[3:2]);
    return {hs, gf2_mul(hs, GF4_PHI) ^ gf2_sq(a[1:0])};
  endfunction

  // In GF(2^2) the inverse equals the square (d^3 = 1); zero maps to zero.
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [1:0] h, l, d, di;
    h  = a[3:2];
    l  = a[1:0];
    d  = gf2_mul(gf2_sq(h), GF4_PHI) ^ gf2_mul(h, l) ^ gf2_sq(l);
    di = gf2_sq(d);
    return {gf2_mul(h, di), gf2_mul(h ^ l, di)};
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ INV_AFFINE_C;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ AFFINE_C;
  endfunction

endpackage

// File: rtl/inv_sbox_composite.sv
// Single-byte combinational AES inverse S-box via GF((2^4)^2) inversion.
// INV_SUB_BYTES_FWD_EN adds a fwd select that reuses the same inverter for the forward S-box.
module inv_sbox_composite
  import aes_sbox_pkg::*;
(
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic       fwd,
`endif
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] field_in;
  logic [7:0] field_inv;
  logic [7:0] mapped_back;
  logic [3:0] ah, al, delta, delta_inv;

`ifdef INV_SUB_BYTES_FWD_EN
  assign field_in = fwd ? bit_mat_mul(ISO_MAP, in_byte)
                        : bit_mat_mul(ISO_MAP, inv_affine(in_byte));
`else
  assign field_in = bit_mat_mul(ISO_MAP, inv_affine(in_byte));
`endif

  // (ah*z + al)^-1 = (ah*z + ah + al) / (ah^2*LAMBDA + ah*al + al^2)
  assign ah        = field_in[7:4];
  assign al        = field_in[3:0];
  assign delta     = gf4_mul(gf4_sq(ah), GF8_LAMBDA) ^ gf4_mul(ah, al) ^ gf4_sq(al);
  assign delta_inv = gf4_inv(delta);
  assign field_inv = {gf4_mul(ah, delta_inv), gf4_mul(ah ^ al, delta_inv)};

  assign mapped_back = bit_mat_mul(INV_ISO_MAP, field_inv);

`ifdef INV_SUB_BYTES_FWD_EN
  assign out_byte = fwd ? fwd_affine(mapped_back) : mapped_back;
`else
  assign out_byte = mapped_back;
`endif

endmodule

// File: rtl/inv_sub_bytes_engine.sv
// Iterative InvSubBytes: LANES bytes per cycle, result 16/LANES cycles after accept; holds output
// until out_ready, refuses input while busy. INV_SUB_BYTES_FWD_EN adds per-block fwd_i mode select.
module inv_sub_bytes_engine
  import aes_sbox_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
`ifdef INV_SUB_BYTES_FWD_EN
  ,
  input  logic         fwd_i
`endif
);

  localparam int NCHUNK = AES_BLOCK_BYTES / LANES;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  isb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  aes_state_t    work_q, work_d;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];
  int            chunk_base;

`ifdef INV_SUB_BYTES_FWD_EN
  logic fwd_q, fwd_d;
`endif

  assign chunk_base = (NCHUNK == 1) ? 0 : int'(cnt_q) * LANES;

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_in[j] = work_q[(chunk_base + j) * 8 +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox_composite u_sbox (
`ifdef INV_SUB_BYTES_FWD_EN
      .fwd      (fwd_q),
`endif
      .in_byte  (lane_in[g]),
      .out_byte (lane_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
`ifdef INV_SUB_BYTES_FWD_EN
    fwd_d   = fwd_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          work_d  = in_state;
`ifdef INV_SUB_BYTES_FWD_EN
          fwd_d   = fwd_i;
`endif
        end
      end
      RUN: begin
        for (int j = 0; j < LANES; j++) begin
          work_d[(chunk_base + j) * 8 +: 8] = lane_out[j];
        end
        if (cnt_q == LAST_CHUNK) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_q   <= fwd_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Directed + random checks of inv_sub_bytes_engine at LANES=4, 1 and 16 against a GF(2^8) model.
module tb_inv_sub_bytes_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         iv  [3];
  logic         ir  [3];
  logic         ov  [3];
  logic         orr [3];
  logic         bz  [3];
  logic [127:0] ist [3];
  logic [127:0] ost [3];

  int n_tests = 0;
  int n_fail  = 0;

  inv_sub_bytes_engine #(.LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(ist[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_state(ost[0]), .busy(bz[0])
`ifdef INV_SUB_BYTES_FWD_EN
    , .fwd_i(1'b0)
`endif
  );

  inv_sub_bytes_engine #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(ist[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_state(ost[1]), .busy(bz[1])
`ifdef INV_SUB_BYTES_FWD_EN
    , .fwd_i(1'b0)
`endif
  );

  inv_sub_bytes_engine #(.LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(ist[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_state(ost[2]), .busy(bz[2])
`ifdef INV_SUB_BYTES_FWD_EN
    , .fwd_i(1'b0)
`endif
  );

  // Reference: polynomial-basis GF(2^8) mod x^8+x^4+x^3+x+1, inverse as a^254.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] ref_inv_sbox(input logic [7:0] b);
    logic [7:0] c;
    logic [7:0] t;
    c = 8'h05;
    for (int i = 0; i < 8; i++) begin
      t[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ c[i];
    end
    return ginv(t);
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] blk);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_inv_sbox(blk[8*i +: 8]);
    return r;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 16 : 1);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one block, wait (bounded) for out_valid; optionally let the engine drain to IDLE.
  task automatic send_block(input int k, input logic [127:0] blk, input bit drain,
                            output logic [127:0] res, output int lat);
    @(negedge clk);
    check($sformatf("ready_before_%0d", k), 128'(ir[k]), 128'd1);
    ist[k] = blk;
    iv[k]  = 1'b1;
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    lat   = 0;
    while (!ov[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("valid_%0d", k), 128'(ov[k]), 128'd1);
    res = ost[k];
    if (drain) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    logic [127:0] held;
    logic [127:0] blk;
    logic [127:0] blk_b;
    int           lat;
    bit           saw_valid;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k]  = 1'b0;
      orr[k] = 1'b1;
      ist[k] = '0;
    end
    #1;
    check("rst_in_ready",  128'(ir[0]), 128'd1);
    check("rst_out_valid", 128'(ov[0]), 128'd0);
    check("rst_busy",      128'(bz[0]), 128'd0);
    check("rst_out_state", ost[0],      128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All 8'h63 block: exact latency and in_ready profile.
    @(negedge clk);
    ist[0] = {16{8'h63}};
    iv[0]  = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    check("t1_ready_e0", 128'(ir[0]), 128'd0);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1_valid_e%0d", e), 128'(ov[0]), 128'(e == 4));
      check($sformatf("t1_ready_e%0d", e), 128'(ir[0]), 128'(e == 5));
      if (e == 4) check("t1_result", ost[0], 128'd0);
    end

    // Repeating {63,7C,00,FF} pattern on all three lane widths.
    for (int k = 0; k < 3; k++) begin
      send_block(k, {4{32'hFF007C63}}, 1'b1, res, lat);
      check($sformatf("t2_pattern_%0d", k), res, {4{32'h7D520100}});
      check($sformatf("t2_latency_%0d", k), 128'(lat), 128'(lat_of(k)));
    end

    // Exhaustive byte coverage; first two blocks against literal FIPS-197 rows.
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(16 * b + i);
      send_block(0, blk, 1'b1, res, lat);
      check($sformatf("t3_exh_blk%0d", b), res, ref_block(blk));
      if (b == 0) check("t3_fips_row0", res, 128'hfbd7f3819ea340bf38a53630d56a0952);
      if (b == 1) check("t3_fips_row1", res, 128'hcbe9dec444438e3487ff2f9b8239e37c);
    end

    // Random blocks on every lane width.
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 6; r++) begin
        blk = {$urandom, $urandom, $urandom, $urandom};
        send_block(k, blk, 1'b1, res, lat);
        check($sformatf("rand_%0d_%0d", k, r), res, ref_block(blk));
        check($sformatf("rand_lat_%0d_%0d", k, r), 128'(lat), 128'(lat_of(k)));
      end
    end

    // Backpressure: hold in DONE for 10 cycles with a competing in_valid.
    orr[0] = 1'b0;
    blk    = {$urandom, $urandom, $urandom, $urandom};
    blk_b  = {$urandom, $urandom, $urandom, $urandom};
    send_block(0, blk, 1'b0, held, lat);
    check("bp_first_result", held, ref_block(blk));
    @(negedge clk);
    ist[0] = blk_b;
    iv[0]  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_valid_c%0d", c), 128'(ov[0]), 128'd1);
      check($sformatf("bp_state_c%0d", c), ost[0], held);
      check($sformatf("bp_ready_c%0d", c), 128'(ir[0]), 128'd0);
    end
    @(negedge clk);
    orr[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 128'(ov[0]), 128'd0);
    check("bp_release_ready", 128'(ir[0]), 128'd1);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    check("bp_accept_busy", 128'(bz[0]), 128'd1);
    lat = 0;
    while (!ov[0] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_second_valid", 128'(ov[0]), 128'd1);
    check("bp_second_result", ost[0], ref_block(blk_b));
    @(posedge clk);
    #1;

    // Reset during RUN cycle 2: block is dropped.
    @(negedge clk);
    ist[0] = {$urandom, $urandom, $urandom, $urandom};
    iv[0]  = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 128'(ir[0]), 128'd1);
    check("mid_rst_valid", 128'(ov[0]), 128'd0);
    check("mid_rst_busy",  128'(bz[0]), 128'd0);
    check("mid_rst_state", ost[0],      128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (ov[0]) saw_valid = 1'b1;
    end
    check("post_rst_no_valid", 128'(saw_valid), 128'd0);
    check("post_rst_state", ost[0], 128'd0);
    blk = {$urandom, $urandom, $urandom, $urandom};
    send_block(0, blk, 1'b1, res, lat);
    check("post_rst_result", res, ref_block(blk));
    check("post_rst_latency", 128'(lat), 128'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
